sc_run_control: RTL and testbench



---
 rtl/sc_runctl_pkg.sv | 19 +
 rtl/sc_key_debounce.sv | 50 +++++
 rtl/sc_run_control.sv | 119 +++++++++++
 tb/tb_sc_run_control.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sc_runctl_pkg.sv
// Shared state type and constants for the run-control sequencer.
package sc_runctl_pkg;

  typedef enum logic [1:0] {
    ST_HALT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STEP  = 2'd2,
    ST_BREAK = 2'd3
  } run_state_t;

  localparam int COUNT_W  = 32;
  localparam int NUM_KEYS = 3;

  // Bit positions of the three keys in the conditioned key vectors.
  localparam int KEY_RUN  = 0;
  localparam int KEY_STEP = 1;
  localparam int KEY_HALT = 2;

endpackage

// File: rtl/sc_key_debounce.sv
// Key conditioner: 2-FF synchronizer, stable-level debouncer and a one-cycle
// press pulse on each accepted high-to-low transition of an active-low key.
module sc_key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clock,
  input  logic reset,
  input  logic key,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic             sync1_reg, sync2_reg;
  logic             level_reg, level_next;
  logic             press_reg;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  // The counter only runs while the sample disagrees with the accepted level.
  always_comb begin
    level_next = level_reg;
    cnt_next   = '0;
    if (sync2_reg != level_reg) begin
      if (cnt_reg == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level_next = sync2_reg;
      end else begin
        cnt_next = cnt_reg + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
      level_reg <= 1'b1;
      cnt_reg   <= '0;
      press_reg <= 1'b0;
    end else begin
      sync1_reg <= key;
      sync2_reg <= sync1_reg;
      level_reg <= level_next;
      cnt_reg   <= cnt_next;
      press_reg <= level_reg & ~level_next;
    end
  end

  assign press = press_reg;

endmodule

// File: rtl/sc_run_control.sv
// Run/halt/step sequencer producing the CPU clock enable and retired count.
// Optional PC breakpoint (BREAK state, skip_bp) enabled by SC_RUNCTL_BREAKPOINT_EN.
module sc_run_control
  import sc_runctl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int START_RUN       = 0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               key_run,
  input  logic               key_step,
  input  logic               key_halt,
  input  logic               bp_enable,
  input  logic [31:0]        bp_addr,
  input  logic [31:0]        pc,
  output logic               cpu_en,
  output logic               halted,
  output logic [1:0]         state,
  output logic [COUNT_W-1:0] inst_count
);

  localparam run_state_t RESET_STATE = (START_RUN != 0) ? ST_RUN : ST_HALT;

  logic [NUM_KEYS-1:0] key_raw;
  logic [NUM_KEYS-1:0] key_press;
  run_state_t          state_reg, state_next;
  logic [COUNT_W-1:0]  inst_count_reg, inst_count_next;
  logic                bp_hit;

  assign key_raw = {key_halt, key_step, key_run};

  genvar gi;
  generate
    for (gi = 0; gi < NUM_KEYS; gi++) begin : g_key
      sc_key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
        .clock(clock),
        .reset(reset),
        .key  (key_raw[gi]),
        .press(key_press[gi])
      );
    end
  endgenerate

`ifdef SC_RUNCTL_BREAKPOINT_EN
  logic skip_bp_reg, skip_bp_next;

  // Compared against the current pc so the breakpoint instruction never executes.
  assign bp_hit = bp_enable & (pc == bp_addr) & ~skip_bp_reg;
`else
  logic unused_bp;

  assign unused_bp = ^{bp_enable, bp_addr, pc};
  assign bp_hit    = 1'b0;
`endif

  assign cpu_en = ((state_reg == ST_RUN) & ~bp_hit) | (state_reg == ST_STEP);
  assign halted = (state_reg == ST_HALT) | (state_reg == ST_BREAK);
  assign state  = state_reg;

  // Pulse priority is halt > step > run in every state that listens to keys.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_HALT: begin
        if (!key_press[KEY_HALT]) begin
          if (key_press[KEY_STEP])     state_next = ST_STEP;
          else if (key_press[KEY_RUN]) state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (key_press[KEY_HALT]) state_next = ST_HALT;
        else if (bp_hit)         state_next = ST_BREAK;
      end
      ST_STEP: state_next = ST_HALT;
      ST_BREAK: begin
        if (key_press[KEY_HALT])      state_next = ST_HALT;
        else if (key_press[KEY_STEP]) state_next = ST_STEP;
        else if (key_press[KEY_RUN])  state_next = ST_RUN;
      end
      default: state_next = ST_HALT;
    endcase
  end

  always_comb begin
    inst_count_next = inst_count_reg;
    if (cpu_en) inst_count_next = inst_count_reg + COUNT_W'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg      <= RESET_STATE;
      inst_count_reg <= '0;
    end else begin
      state_reg      <= state_next;
      inst_count_reg <= inst_count_next;
    end
  end

  assign inst_count = inst_count_reg;

`ifdef SC_RUNCTL_BREAKPOINT_EN
  // Resume from BREAK ignores the breakpoint until one instruction has retired.
  always_comb begin
    skip_bp_next = skip_bp_reg;
    if ((state_reg == ST_RUN) && cpu_en)                   skip_bp_next = 1'b0;
    if ((state_reg == ST_BREAK) && (state_next == ST_RUN)) skip_bp_next = 1'b1;
    if (state_next == ST_HALT)                             skip_bp_next = 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) skip_bp_reg <= 1'b0;
    else       skip_bp_reg <= skip_bp_next;
  end
`endif

endmodule

// File: tb/tb_sc_run_control.sv
// Self-checking bench for sc_run_control: vector table, directed corner cases
// and random key/pc stimulus against a behavioural reference model.
module tb_sc_run_control;

  localparam int D = 4;
  localparam logic [1:0] S_HALT = 2'd0, S_RUN = 2'd1, S_STEP = 2'd2, S_BREAK = 2'd3;

  logic        clock = 1'b0;
  logic        reset;
  logic [2:0]  key_drv;
  logic        bp_enable;
  logic [31:0] bp_addr;
  logic [31:0] pc;
  logic        cpu_en;
  logic        halted;
  logic [1:0]  state;
  logic [31:0] inst_count;

  sc_run_control #(
    .DEBOUNCE_CYCLES(D),
    .START_RUN      (0)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .key_run   (key_drv[0]),
    .key_step  (key_drv[1]),
    .key_halt  (key_drv[2]),
    .bp_enable (bp_enable),
    .bp_addr   (bp_addr),
    .pc        (pc),
    .cpu_en    (cpu_en),
    .halted    (halted),
    .state     (state),
    .inst_count(inst_count)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;
  int en_seen = 0;

  // Reference model: key history windows, state, skip flag, retired count.
  logic [1:0]  m_state;
  logic        m_skip;
  logic [31:0] m_count;
  logic [2:0]  m_level;
  logic [2:0]  m_press;
  logic        m_last_en;
  logic        raw_hist [3][D+2];
  logic        auto_pc;

  typedef struct {
    logic [2:0]  mask;
    int          hold;
    logic [1:0]  exp_state;
    logic        chk_cnt;
    logic [31:0] exp_cnt;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic m_bp_hit();
`ifdef SC_RUNCTL_BREAKPOINT_EN
    return bp_enable && (pc == bp_addr) && !m_skip;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic m_en();
    return ((m_state == S_RUN) && !m_bp_hit()) || (m_state == S_STEP);
  endfunction

  task automatic model_reset();
    m_state   = S_HALT;
    m_skip    = 1'b0;
    m_count   = 32'd0;
    m_level   = 3'b111;
    m_press   = 3'b000;
    m_last_en = 1'b0;
    for (int k = 0; k < 3; k++)
      for (int j = 0; j < D + 2; j++) raw_hist[k][j] = 1'b1;
  endtask

  // Advance the model across one rising edge using the inputs present now.
  task automatic model_update();
    logic       en;
    logic       hit;
    logic [1:0] nxt;
    en  = m_en();
    hit = m_bp_hit();
    m_last_en = en;
    if (en) m_count = m_count + 32'd1;
    nxt = m_state;
    case (m_state)
      S_HALT:  if (m_press[2]) nxt = S_HALT;
               else if (m_press[1]) nxt = S_STEP;
               else if (m_press[0]) nxt = S_RUN;
      S_RUN:   if (m_press[2]) nxt = S_HALT;
               else if (hit) nxt = S_BREAK;
      S_STEP:  nxt = S_HALT;
      default: if (m_press[2]) nxt = S_HALT;
               else if (m_press[1]) nxt = S_STEP;
               else if (m_press[0]) nxt = S_RUN;
    endcase
    if ((m_state == S_RUN) && en) m_skip = 1'b0;
    if ((m_state == S_BREAK) && (nxt == S_RUN)) m_skip = 1'b1;
    if (nxt == S_HALT) m_skip = 1'b0;
    m_state = nxt;
    // A key level is accepted once D consecutive synchronized samples disagree with it.
    for (int k = 0; k < 3; k++) begin
      logic all_diff;
      for (int j = D + 1; j > 0; j--) raw_hist[k][j] = raw_hist[k][j-1];
      raw_hist[k][0] = key_drv[k];
      all_diff = 1'b1;
      for (int j = 2; j < D + 2; j++)
        if (raw_hist[k][j] == m_level[k]) all_diff = 1'b0;
      m_press[k] = 1'b0;
      if (all_diff) begin
        m_press[k] = m_level[k];
        m_level[k] = ~m_level[k];
      end
    end
  endtask

  task automatic check_outputs();
    check("cpu_en", 32'(cpu_en), 32'(m_en()));
    check("halted", 32'(halted), 32'((m_state == S_HALT) || (m_state == S_BREAK)));
    check("state", 32'(state), 32'(m_state));
    check("inst_count", inst_count, m_count);
    if (cpu_en === 1'b1) en_seen++;
  endtask

  // Called at a falling edge with inputs applied; returns at the next falling edge.
  task automatic step_cycle();
    #1;
    check_outputs();
    @(posedge clock);
    model_update();
    @(negedge clock);
    if (auto_pc && m_last_en) pc = (pc == 32'h1C) ? 32'h0 : pc + 32'd4;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    check("rst_state", 32'(state), 32'(S_HALT));
    check("rst_cpu_en", 32'(cpu_en), 32'd0);
    check("rst_halted", 32'(halted), 32'd1);
    check("rst_count", inst_count, 32'd0);
    model_reset();
    @(posedge clock);
    #1;
    check("rst_hold_cpu_en", 32'(cpu_en), 32'd0);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic press_keys(input logic [2:0] mask, input int hold, input int settle);
    key_drv = ~mask;
    for (int i = 0; i < hold; i++) step_cycle();
    key_drv = 3'b111;
    for (int i = 0; i < settle; i++) step_cycle();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required $finish before t=2000000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] s_count;
    int          s_seen;
    int          hold_left [3];

    key_drv   = 3'b111;
    bp_enable = 1'b0;
    bp_addr   = 32'h0;
    pc        = 32'h100;
    auto_pc   = 1'b0;
    reset     = 1'b0;
    @(negedge clock);
    do_reset();

    vecs[0] = '{3'b010, 20, S_HALT, 1'b1, 32'd1};  // held step: exactly one instruction
    vecs[1] = '{3'b001,  2, S_HALT, 1'b1, 32'd1};  // short bounce: no pulse
    vecs[2] = '{3'b101,  6, S_HALT, 1'b1, 32'd1};  // halt beats run
    vecs[3] = '{3'b011,  6, S_HALT, 1'b1, 32'd2};  // step beats run
    vecs[4] = '{3'b001,  6, S_RUN,  1'b0, 32'd0};
    vecs[5] = '{3'b100,  6, S_HALT, 1'b0, 32'd0};
    vecs[6] = '{3'b110,  6, S_HALT, 1'b0, 32'd0};  // halt beats step
    for (int v = 0; v < 7; v++) begin
      press_keys(vecs[v].mask, vecs[v].hold, 14);
      check("vec_state", 32'(state), 32'(vecs[v].exp_state));
      if (vecs[v].chk_cnt) check("vec_count", inst_count, vecs[v].exp_cnt);
      $display("vec %0d keys=%b hold=%0d state=%0d count=%0d", v, vecs[v].mask, vecs[v].hold, state, inst_count);
    end

    // Run then halt: retired count matches observed enable cycles.
    s_count = m_count;
    s_seen  = en_seen;
    press_keys(3'b001, 6, 14);
    press_keys(3'b100, 6, 14);
    check("run_halt_state", 32'(state), 32'(S_HALT));
    check("run_halt_count", inst_count - s_count, 32'(en_seen - s_seen));
    $display("run/halt: %0d enabled cycles, count=%0d", en_seen - s_seen, inst_count);

    // Breakpoint at 0x0C with pc walking 0..0x1C.
    pc        = 32'h0;
    auto_pc   = 1'b1;
    bp_enable = 1'b1;
    bp_addr   = 32'hC;
    press_keys(3'b001, 6, 14);
`ifdef SC_RUNCTL_BREAKPOINT_EN
    check("bp_state", 32'(state), 32'(S_BREAK));
    check("bp_pc", pc, 32'hC);
    check("bp_cpu_en", 32'(cpu_en), 32'd0);
    s_seen = en_seen;
    press_keys(3'b001, 6, 14);
    check("bp_again_state", 32'(state), 32'(S_BREAK));
    check("bp_again_pc", pc, 32'hC);
    check("bp_loop_len", 32'(en_seen - s_seen), 32'd8);
`else
    check("nobp_state", 32'(state), 32'(S_RUN));
`endif
    $display("breakpoint: state=%0d pc=%h count=%0d", state, pc, inst_count);
    press_keys(3'b100, 6, 14);
    check("bp_halt_state", 32'(state), 32'(S_HALT));
    auto_pc   = 1'b0;
    bp_enable = 1'b0;

    // Wrap: preload all-ones, one step rolls the counter to zero.
    force dut.inst_count_next = 32'hFFFF_FFFF;
    step_cycle();
    release dut.inst_count_next;
    m_count = 32'hFFFF_FFFF;
    press_keys(3'b010, 6, 14);
    check("wrap_count", inst_count, 32'd0);
    check("wrap_state", 32'(state), 32'(S_HALT));
    $display("wrap: count=%0d", inst_count);

    // Reset while running with an all-ones count.
    press_keys(3'b001, 6, 4);
    force dut.inst_count_next = 32'hFFFF_FFFF;
    step_cycle();
    release dut.inst_count_next;
    m_count = 32'hFFFF_FFFF;
    #1;
    check("pre_rst_count", inst_count, 32'hFFFF_FFFF);
    check("pre_rst_state", 32'(state), 32'(S_RUN));
    do_reset();
    $display("reset in run: state=%0d count=%0d", state, inst_count);

    // Random keys, pc and breakpoint settings against the model.
    auto_pc = 1'b1;
    pc      = 32'h0;
    for (int k = 0; k < 3; k++) hold_left[k] = 0;
    for (int c = 0; c < 1500; c++) begin
      for (int k = 0; k < 3; k++) begin
        if (hold_left[k] > 0) begin
          hold_left[k]--;
          key_drv[k] = 1'b0;
        end else begin
          key_drv[k] = 1'b1;
          if ($urandom_range(0, (k == 0) ? 11 : (k == 1) ? 19 : 29) == 0)
            hold_left[k] = int'($urandom_range(1, 9));
        end
      end
      if ($urandom_range(0, 24) == 0) begin
        bp_enable = ~bp_enable;
        bp_addr   = ($urandom_range(0, 1) == 0) ? 32'hC : 32'($urandom_range(0, 7)) << 2;
      end
      if ($urandom_range(0, 39) == 0) pc = 32'($urandom_range(0, 7)) << 2;
      if ($urandom_range(0, 299) == 0) begin
        key_drv = 3'b111;
        for (int k = 0; k < 3; k++) hold_left[k] = 0;
        do_reset();
      end
      step_cycle();
    end
    $display("random phase: count=%0d state=%0d", inst_count, state);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
